// File: rtl/median_capture_pkg.sv
// Shared definitions for the median capture block: state encoding and default widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package median_capture_pkg;

    localparam int DW_DEFAULT = 16;

    // IDLE is reserved; the controller leaves reset straight into WAIT.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Counter width able to hold 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/median_capture_if.sv
// Valid/ready stream carrying captured samples downstream.
// Latency: wires only.
// Backpressure: the sink holds m_ready low to stall the source.
interface median_capture_if #(
    parameter int DW = median_capture_pkg::DW_DEFAULT
);
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/median_capture_capture_fifo.sv
// Generic synchronous FIFO with a registered first-word-fall-through head.
// Latency: a push is visible on head_valid/head_data one clock later.
// Backpressure: pushes while full are ignored unless a pop happens in the same cycle.
module capture_fifo
    import median_capture_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic          head_valid,
    output logic [DW-1:0] head_data
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_n;
    logic [AW:0]   rd_ptr_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] head_n;

    // Extra pointer MSB tells a full ring from an empty one.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en    = pop & ~empty & ~clear;
    assign wr_en    = push & (~full | rd_en) & ~clear;
    assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, wr_en};
    assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, rd_en};

    // Next head word; bypass the write data when it lands in the slot about to be shown.
    always_comb begin
        head_n = mem[rd_ptr_n[AW-1:0]];
        if (wr_en && (rd_ptr_n[AW-1:0] == wr_ptr[AW-1:0]))
            head_n = push_data;
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Pointers and the registered head; head_data keeps its last value when the FIFO drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            head_valid <= (wr_ptr_n != rd_ptr_n);
            if (wr_ptr_n != rd_ptr_n)
                head_data <= head_n;
        end
    end

endmodule

// File: rtl/median_capture.sv
// Samples the median filter output on a fixed cadence after a warm-up delay and queues it downstream.
// Latency: a capture edge shows on m_valid/m_data one clock later; optional chksum (MEDIAN_CAPTURE_CHKSUM_EN).
// Backpressure: m_ready low lets the FIFO fill; captures into a full FIFO are dropped and flagged in overflow.
module median_capture
    import median_capture_pkg::*;
#(
    parameter int DW            = DW_DEFAULT,
    parameter int SAMPLE_PERIOD = 2,
    parameter int START_DELAY   = 10,
    parameter int DEPTH         = 8,
    parameter int CW            = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] median,
    input  logic          enable,
    input  logic          clear,
    median_capture_if.master m,
    output logic          overflow,
    output logic [CW-1:0] captured
`ifdef MEDIAN_CAPTURE_CHKSUM_EN
    ,
    output logic [DW-1:0] chksum
`endif
);
    localparam int DCW = cnt_width(START_DELAY);
    localparam int PCW = cnt_width(SAMPLE_PERIOD);
    localparam logic [DCW-1:0] DLY_LAST = DCW'(START_DELAY - 1);
    localparam logic [PCW-1:0] PH_LAST  = PCW'(SAMPLE_PERIOD - 1);

    state_t         state;
    logic [DCW-1:0] dcnt;
    logic [PCW-1:0] phase;
    logic           strobe;
    logic           pop;
    logic           accept;
    logic           fifo_full;
    logic           fifo_empty;

    // Capture fires on the last warm-up clock, then every time the phase wraps.
    always_comb begin
        strobe = 1'b0;
        if (!clear && enable) begin
            if (state == ST_WAIT)
                strobe = (dcnt == DLY_LAST);
            else if (state == ST_RUN)
                strobe = (phase == PH_LAST);
        end
    end

    assign pop    = ~fifo_empty & m.m_ready;
    assign accept = strobe & (~fifo_full | pop);

    // Warm-up / cadence controller; counters freeze while enable is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_WAIT;
            dcnt  <= '0;
            phase <= '0;
        end else if (clear) begin
            state <= ST_WAIT;
            dcnt  <= '0;
            phase <= '0;
        end else if (enable) begin
            case (state)
                ST_WAIT: begin
                    if (dcnt == DLY_LAST) begin
                        state <= ST_RUN;
                        phase <= '0;
                    end else begin
                        dcnt <= dcnt + DCW'(1);
                    end
                end
                ST_RUN: begin
                    phase <= (phase == PH_LAST) ? '0 : phase + PCW'(1);
                end
                default: begin
                    state <= ST_WAIT;
                    dcnt  <= '0;
                    phase <= '0;
                end
            endcase
        end
    end

    // Sticky drop flag and count of samples that actually entered the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            captured <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            captured <= '0;
        end else begin
            if (strobe && fifo_full && !pop)
                overflow <= 1'b1;
            if (accept)
                captured <= captured + CW'(1);
        end
    end

`ifdef MEDIAN_CAPTURE_CHKSUM_EN
    // Running modulo sum of accepted samples; dropped samples never reach it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            chksum <= '0;
        else if (clear)
            chksum <= '0;
        else if (accept)
            chksum <= chksum + median;
    end
`endif

    capture_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .push       (strobe),
        .push_data  (median),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_valid (m.m_valid),
        .head_data  (m.m_data)
    );

endmodule

// File: tb/tb_median_capture.sv
// Randomised and directed check of median_capture against a queue-based reference model.
// Latency: model outputs are compared at every falling edge.
// Backpressure: m_ready is driven randomly with varying duty to provoke full/overflow cases.
module tb_median_capture;
    localparam int DW    = 16;
    localparam int SP    = 2;
    localparam int SD    = 10;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          enable = 1'b0;
    logic          clear  = 1'b0;
    logic [DW-1:0] median = '0;
    logic          overflow;
    logic [CW-1:0] captured;
`ifdef MEDIAN_CAPTURE_CHKSUM_EN
    logic [DW-1:0] chksum;
`endif

    median_capture_if #(.DW(DW)) mif ();

    always #5 clk = ~clk;

    median_capture #(
        .DW            (DW),
        .SAMPLE_PERIOD (SP),
        .START_DELAY   (SD),
        .DEPTH         (DEPTH),
        .CW            (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .median   (median),
        .enable   (enable),
        .clear    (clear),
        .m        (mif),
        .overflow (overflow),
        .captured (captured)
`ifdef MEDIAN_CAPTURE_CHKSUM_EN
        ,
        .chksum   (chksum)
`endif
    );

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: enabled clocks since the last flush decide capture moments.
    int            ecnt  = 0;
    logic [DW-1:0] q[$];
    logic          e_ovf = 1'b0;
    logic [CW-1:0] e_cap = '0;
    logic [DW-1:0] e_dat = '0;
    logic [DW-1:0] e_sum = '0;
    bit            m_pop;
    bit            m_cap;

    always @(posedge clk) begin
        if (!reset) begin
            ecnt = 0; q.delete(); e_ovf = 1'b0; e_cap = '0; e_dat = '0; e_sum = '0;
        end else if (clear) begin
            ecnt = 0; q.delete(); e_ovf = 1'b0; e_cap = '0; e_sum = '0;
        end else begin
            m_pop = (q.size() > 0) && mif.m_ready;
            m_cap = 1'b0;
            if (enable) begin
                ecnt++;
                m_cap = (ecnt >= SD) && (((ecnt - SD) % SP) == 0);
            end
            if (m_pop)
                void'(q.pop_front());
            if (m_cap) begin
                if (q.size() < DEPTH) begin
                    q.push_back(median);
                    e_cap = e_cap + 1'b1;
                    e_sum = e_sum + median;
                end else begin
                    e_ovf = 1'b1;
                end
            end
            if (q.size() > 0)
                e_dat = q[0];
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("m_valid", {31'd0, mif.m_valid}, {31'd0, (q.size() > 0)});
        chk("m_data", {16'd0, mif.m_data}, {16'd0, e_dat});
        chk("overflow", {31'd0, overflow}, {31'd0, e_ovf});
        chk("captured", {16'd0, captured}, {16'd0, e_cap});
`ifdef MEDIAN_CAPTURE_CHKSUM_EN
        chk("chksum", {16'd0, chksum}, {16'd0, e_sum});
`endif
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    int mode;
    logic [DW-1:0] exp_v;

    initial begin
        mif.m_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, mif.m_valid}, 32'd0);
        chk("rst_data", {16'd0, mif.m_data}, 32'd0);
        chk("rst_captured", {16'd0, captured}, 32'd0);

        // Warm-up: first capture on the tenth enabled clock.
        reset = 1'b1; enable = 1'b1; median = 16'd76; mif.m_ready = 1'b1;
        repeat (9) tick();
        chk("warm_novalid", {31'd0, mif.m_valid}, 32'd0);
        tick();
        chk("warm_valid", {31'd0, mif.m_valid}, 32'd1);
        chk("warm_data", {16'd0, mif.m_data}, 32'd76);
        chk("warm_cap", {16'd0, captured}, 32'd1);

        // Cadence: one capture every two clocks.
        median = 16'd79;
        tick();
        chk("cad_gap", {31'd0, mif.m_valid}, 32'd0);
        tick();
        chk("cad_79", {16'd0, mif.m_data}, 32'd79);
        median = 16'd80; tick(); tick();
        chk("cad_80", {16'd0, mif.m_data}, 32'd80);
        median = 16'd83; tick(); tick();
        chk("cad_83", {16'd0, mif.m_data}, 32'd83);
        median = 16'd80; tick(); tick();
        chk("cad_80b", {16'd0, mif.m_data}, 32'd80);
        chk("cad_cap", {16'd0, captured}, 32'd5);

        // Overflow: nine strobes into a stalled FIFO.
        tick();
        mif.m_ready = 1'b0; median = 16'd123;
        repeat (18) tick();
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_cap", {16'd0, captured}, 32'd13);
        enable = 1'b0; mif.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {31'd0, mif.m_valid}, 32'd1);
            chk("drain_123", {16'd0, mif.m_data}, 32'd123);
            tick();
        end
        chk("drain_empty", {31'd0, mif.m_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Clear with three entries pending, then warm-up restarts.
        enable = 1'b1; mif.m_ready = 1'b0; median = 16'd55;
        repeat (6) tick();
        chk("pre_clr_cap", {16'd0, captured}, 32'd16);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_valid", {31'd0, mif.m_valid}, 32'd0);
        chk("clr_cap", {16'd0, captured}, 32'd0);
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        repeat (9) tick();
        chk("clr_wait", {31'd0, mif.m_valid}, 32'd0);
        tick();
        chk("clr_first", {31'd0, mif.m_valid}, 32'd1);
        chk("clr_first_cap", {16'd0, captured}, 32'd1);

        // Full FIFO with push and pop on the same strobe.
        repeat (14) tick();
        chk("full_cap", {16'd0, captured}, 32'd8);
        tick();
        median = 16'd200; mif.m_ready = 1'b1;
        tick();
        chk("pp_ovf", {31'd0, overflow}, 32'd0);
        chk("pp_cap", {16'd0, captured}, 32'd9);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_v = (i == 7) ? 16'd200 : 16'd55;
            chk("pp_drain", {16'd0, mif.m_data}, {16'd0, exp_v});
            tick();
        end
        chk("pp_empty", {31'd0, mif.m_valid}, 32'd0);

`ifdef MEDIAN_CAPTURE_CHKSUM_EN
        clear = 1'b1; enable = 1'b1; median = 16'd64;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        median = 16'd62; tick(); tick();
        median = 16'd76; tick(); tick();
        chk("sum_202", {16'd0, chksum}, 32'd202);
        median = 16'hFFFF; tick(); tick();
        median = 16'd2; tick(); tick();
        chk("sum_wrap", {16'd0, chksum}, 32'd203);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("sum_clr", {16'd0, chksum}, 32'd0);
`endif

        // Random traffic with occasional clear and reset.
        for (int i = 0; i < 3000; i++) begin
            mode        = (i / 300) % 3;
            enable      = ($urandom_range(0, 9) < 8);
            mif.m_ready = (mode == 0) ? ($urandom_range(0, 3) != 0) :
                          (mode == 1) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
            median      = DW'($urandom);
            clear       = ($urandom_range(0, 249) == 0);
            reset       = ($urandom_range(0, 599) != 0);
            tick();
        end
        reset = 1'b1; clear = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
